des_ip_loader: RTL and testbench

Input front-end of the DES datapath and the counterpart of the final inverse-permutation stage. It accepts a 64-bit plaintext or ciphertext block as a stream of narrow beats over a valid/ready handshake. It assembles the block, applies the DES initial permutation (IP), and presents the result as L0/R0 halves to the round engine over a registered valid/ready output. The block is single-clock, with one assembly register and one output register, so assembly of the next block overlaps with the round engine consuming the current one.

---
 rtl/des_pkg.sv | 37 +++
 rtl/des_initial_permutation.sv | 13 +
 rtl/des_ip_loader.sv | 96 +++++++++
 tb/tb_des_ip_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: block geometry, the initial permutation table and
// reference IP / IP^-1 functions.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;

  // Entry n (0-based) names the 1-based block bit that lands in output bit n+1.
  localparam int unsigned DES_IP_TABLE [DES_BLOCK_W] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  // Bit 1 of the DES numbering is the vector MSB, hence the 63-n / 64-x flips.
  function automatic logic [DES_BLOCK_W-1:0] des_ip(input logic [DES_BLOCK_W-1:0] blk);
    logic [DES_BLOCK_W-1:0] o;
    o = '0;
    for (int n = 0; n < DES_BLOCK_W; n++)
      o[6'(63 - n)] = blk[6'(64 - DES_IP_TABLE[n])];
    return o;
  endfunction

  function automatic logic [DES_BLOCK_W-1:0] des_ip_inv(input logic [DES_BLOCK_W-1:0] blk);
    logic [DES_BLOCK_W-1:0] o;
    o = '0;
    for (int n = 0; n < DES_BLOCK_W; n++)
      o[6'(64 - DES_IP_TABLE[n])] = blk[6'(63 - n)];
    return o;
  endfunction

endpackage

// File: rtl/des_initial_permutation.sv
// Pure wiring: DES initial permutation on a 64-bit block, MSB = DES bit 1.
module des_initial_permutation
  import des_pkg::*;
(
  input  logic [DES_BLOCK_W-1:0] block_i,
  output logic [DES_BLOCK_W-1:0] perm_o
);

  for (genvar n = 0; n < DES_BLOCK_W; n++) begin : g_bit
    assign perm_o[63-n] = block_i[64-DES_IP_TABLE[n]];
  end

endmodule

// File: rtl/des_ip_loader.sv
// DES input front-end: assembles IN_W-bit beats into a 64-bit block, applies
// IP and holds L0/R0 in an output register behind a valid/ready handshake.
module des_ip_loader
  import des_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [IN_W-1:0]           in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [DES_HALF_W-1:0]     l0_o,
  output logic [DES_HALF_W-1:0]     r0_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(64/IN_W):0]  beat_cnt_o
);

  localparam int BEATS = DES_BLOCK_W / IN_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int ASM_W = (IN_W == DES_BLOCK_W) ? 1 : DES_BLOCK_W - IN_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (!(IN_W == 8 || IN_W == 16 || IN_W == 32 || IN_W == 64)) begin : g_bad_in_w
    $error("des_ip_loader: IN_W must be 8, 16, 32 or 64");
  end

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ASM_W-1:0]       asm_q, asm_d;
  logic [DES_BLOCK_W-1:0] out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [DES_BLOCK_W-1:0] block, perm;
  logic                   last_beat, accept, load;

  // The final beat joins the block combinationally so IP lands in one edge.
  if (IN_W == DES_BLOCK_W) begin : g_full_beat
    assign block = in_data_i;
  end else begin : g_narrow_beat
    assign block = {asm_q, in_data_i};
  end

  des_initial_permutation u_ip (
    .block_i (block),
    .perm_o  (perm)
  );

  assign last_beat  = (cnt_q == LAST_CNT);
  assign in_ready_o = !clear_i && !(last_beat && out_valid_q && !out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign load       = accept && last_beat;

  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        asm_d = block[ASM_W-1:0];
        cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
      // A drain on the same edge as a load keeps valid high with new data.
      if (load) begin
        out_d       = perm;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign l0_o        = out_q[DES_BLOCK_W-1:DES_HALF_W];
  assign r0_o        = out_q[DES_HALF_W-1:0];
  assign out_valid_o = out_valid_q;
  assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_des_ip_loader.sv
// Directed checks on an IN_W=8 loader plus randomized streams into loaders of
// every legal beat width, scored against an arithmetic IP reference.
module tb_des_ip_loader;
  import des_pkg::*;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // IP rows start at 58,60,62,64,57,59,61,63 and step down by 8 per column.
  function automatic logic [63:0] ref_ip(input logic [63:0] b);
    logic [63:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        src = ((r < 4) ? 58 + 2 * r : 49 + 2 * r) - 8 * c;
        o[6'(63 - (8 * r + c))] = b[6'(64 - src)];
      end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed DUT (IN_W = 8) ----------------
  logic        rst_n, clr, d_vld, d_rdy, o_vld, o_rdy;
  logic [7:0]  d_in;
  logic [31:0] l0, r0;
  logic [3:0]  cnt;
  logic        rrst_n;

  des_ip_loader #(.IN_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clr),
    .in_data_i   (d_in),
    .in_valid_i  (d_vld),
    .in_ready_o  (d_rdy),
    .l0_o        (l0),
    .r0_o        (r0),
    .out_valid_o (o_vld),
    .out_ready_i (o_rdy),
    .beat_cnt_o  (cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] b);
    int t;
    d_in  = b;
    d_vld = 1'b1;
    t     = 0;
    @(negedge clk);
    while (!d_rdy && t < 50) begin
      step();
      @(negedge clk);
      t++;
    end
    if (!d_rdy) chk("beat_accept_timeout", 64'(d_rdy), 64'd1);
    step();
    d_vld = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk);
    for (int k = 0; k < 8; k++) send_beat(blk[63 - 8 * k -: 8]);
  endtask

  // ---------------- randomized DUTs, one per legal width ----------------
  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int W  = 8 << g;
    localparam int NB = 64 / W;
    logic [W-1:0]          din;
    logic                  vld, rdy, ovld, ordy;
    logic                  done = 1'b0;
    logic [31:0]           rl0, rr0;
    logic [$clog2(NB):0]   rcnt;
    logic [63:0]           q [$];
    int                    nout = 0;

    des_ip_loader #(.IN_W(W)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rrst_n),
      .clear_i     (1'b0),
      .in_data_i   (din),
      .in_valid_i  (vld),
      .in_ready_o  (rdy),
      .l0_o        (rl0),
      .r0_o        (rr0),
      .out_valid_o (ovld),
      .out_ready_i (ordy),
      .beat_cnt_o  (rcnt)
    );

    initial begin
      ordy = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      if (rrst_n && ovld && ordy) begin
        logic [63:0] blk;
        chk($sformatf("w%0d_out_expected", W), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          blk = q.pop_front();
          chk($sformatf("w%0d_blk%0d_ip", W, nout), {rl0, rr0}, ref_ip(blk));
          chk($sformatf("w%0d_blk%0d_inv", W, nout), des_ip_inv({rl0, rr0}), blk);
          nout++;
        end
      end
    end

    initial begin
      logic [63:0] blk;
      int t;
      vld = 1'b0;
      din = '0;
      wait (rrst_n === 1'b1);
      step();
      for (int b = 0; b < 200; b++) begin
        blk = {$urandom, $urandom};
        q.push_back(blk);
        for (int k = 0; k < NB; k++) begin
          while ($urandom_range(0, 9) < 3) begin
            vld = 1'b0;
            step();
          end
          din = blk[63 - k * W -: W];
          vld = 1'b1;
          t   = 0;
          @(negedge clk);
          while (!rdy && t < 100) begin
            step();
            @(negedge clk);
            t++;
          end
          if (!rdy) chk($sformatf("w%0d_beat_timeout", W), 64'(rdy), 64'd1);
          step();
        end
        vld = 1'b0;
      end
      t = 0;
      while (q.size() != 0 && t < 1000) begin
        step();
        t++;
      end
      chk($sformatf("w%0d_queue_drained", W), 64'(q.size()), 64'd0);
      chk($sformatf("w%0d_out_count", W), 64'(nout), 64'd200);
      chk($sformatf("w%0d_cnt_idle", W), 64'(rcnt), 64'd0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] a, b, x, f, h;
    rst_n  = 1'b0;
    rrst_n = 1'b0;
    clr    = 1'b0;
    d_vld  = 1'b0;
    d_in   = '0;
    o_rdy  = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 64'(o_vld), 64'd0);
    chk("rst_l0_r0", {l0, r0}, 64'd0);
    chk("rst_beat_cnt", 64'(cnt), 64'd0);
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(d_rdy), 64'd1);

    // known vector, back-to-back beats
    o_rdy = 1'b1;
    a = 64'h0123456789ABCDEF;
    for (int k = 0; k < 7; k++) send_beat(a[63 - 8 * k -: 8]);
    chk("t1_valid_before_last", 64'(o_vld), 64'd0);
    chk("t1_cnt_before_last", 64'(cnt), 64'd7);
    send_beat(a[7:0]);
    chk("t1_valid", 64'(o_vld), 64'd1);
    chk("t1_l0_r0", {l0, r0}, 64'hCC00CCFF_F0AAF0AA);
    chk("t1_ref", {l0, r0}, ref_ip(a));
    step();
    chk("t1_drained", 64'(o_vld), 64'd0);

    // single-bit and all-ones mapping
    send_block(64'h8000000000000000);
    chk("t2_bit1", {l0, r0}, 64'h00000000_01000000);
    send_block(64'hFFFFFFFFFFFFFFFF);
    chk("t2_ones", {l0, r0}, 64'hFFFFFFFF_FFFFFFFF);
    step();

    // output backpressure
    o_rdy = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send_block(a);
    chk("t3_a_valid", 64'(o_vld), 64'd1);
    chk("t3_a_data", {l0, r0}, ref_ip(a));
    for (int k = 0; k < 7; k++) send_beat(b[63 - 8 * k -: 8]);
    chk("t3_b_cnt7", 64'(cnt), 64'd7);
    d_in  = b[7:0];
    d_vld = 1'b1;
    @(negedge clk);
    chk("t3_stall", 64'(d_rdy), 64'd0);
    step();
    step();
    @(negedge clk);
    chk("t3_still_stalled", 64'(d_rdy), 64'd0);
    chk("t3_a_held", {l0, r0}, ref_ip(a));
    chk("t3_a_held_valid", 64'(o_vld), 64'd1);
    step();
    o_rdy = 1'b1;
    #1;
    chk("t3_ready_on_drain", 64'(d_rdy), 64'd1);
    step();
    d_vld = 1'b0;
    chk("t3_swap_valid", 64'(o_vld), 64'd1);
    chk("t3_b_data", {l0, r0}, ref_ip(b));
    chk("t3_cnt_wrap", 64'(cnt), 64'd0);
    step();
    chk("t3_b_drained", 64'(o_vld), 64'd0);

    // clear mid-block, with a held output
    o_rdy = 1'b0;
    x = {$urandom, $urandom};
    send_block(x);
    chk("t5_x_valid", 64'(o_vld), 64'd1);
    for (int k = 0; k < 5; k++) send_beat(8'($urandom));
    chk("t5_cnt5", 64'(cnt), 64'd5);
    clr   = 1'b1;
    d_in  = 8'hA5;
    d_vld = 1'b1;
    #1;
    chk("t5_ready_in_clear", 64'(d_rdy), 64'd0);
    step();
    clr   = 1'b0;
    d_vld = 1'b0;
    chk("t5_cnt_cleared", 64'(cnt), 64'd0);
    chk("t5_valid_cleared", 64'(o_vld), 64'd0);
    o_rdy = 1'b1;
    f = {$urandom, $urandom};
    send_block(f);
    chk("t5_fresh_valid", 64'(o_vld), 64'd1);
    chk("t5_fresh_data", {l0, r0}, ref_ip(f));
    step();

    // asynchronous reset mid-block with a held output
    o_rdy = 1'b0;
    send_block({$urandom, $urandom});
    for (int k = 0; k < 3; k++) send_beat(8'($urandom));
    chk("t6_cnt3", 64'(cnt), 64'd3);
    chk("t6_valid_before", 64'(o_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(o_vld), 64'd0);
    chk("t6_async_data", {l0, r0}, 64'd0);
    chk("t6_async_cnt", 64'(cnt), 64'd0);
    step();
    rst_n = 1'b1;
    o_rdy = 1'b1;
    h = {$urandom, $urandom};
    send_block(h);
    chk("t6_after_valid", 64'(o_vld), 64'd1);
    chk("t6_after_data", {l0, r0}, ref_ip(h));

    // randomized streams on all widths
    rrst_n = 1'b1;
    for (int t = 0; t < 20000; t++) begin
      if (g_w[0].done && g_w[1].done && g_w[2].done && g_w[3].done) break;
      step();
    end
    chk("rand_all_done", 64'({g_w[0].done, g_w[1].done, g_w[2].done, g_w[3].done}), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
